// File: rtl/riscv_hazard.sv
// Hazard and forwarding controller opposite the EX stage: tracks rd of older
// instructions, drives operand-forwarding selects, stalls/flushes, and counts events.
module riscv_hazard #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_ID_rs1,
  input  logic [4:0]       i_ID_rs2,
  input  logic [4:0]       i_EX_rs1,
  input  logic [4:0]       i_EX_rs2,
  input  logic [4:0]       i_EX_rd,
  input  logic             i_EX_reg_wr_en,
  input  logic [1:0]       i_EX_src_rd,
  input  logic [1:0]       i_EX_src_pc,
  output logic [1:0]       o_EX_fwd_sel_a,
  output logic [1:0]       o_EX_fwd_sel_b,
  output logic             o_stall,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd0;

  // XLEN only sizes datapath fields that never reach this block.
  if (XLEN < 1) begin : g_xlen_unused
  end

  logic [4:0] mem_rd;
  logic       mem_wr_en;
  logic [1:0] mem_src_rd;
  logic [4:0] wb_rd;
  logic       wb_wr_en;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem_rd     <= 5'd0;
      mem_wr_en  <= 1'b0;
      mem_src_rd <= SRC_ALU;
      wb_rd      <= 5'd0;
      wb_wr_en   <= 1'b0;
    end else begin
      mem_rd     <= i_EX_rd;
      mem_wr_en  <= i_EX_reg_wr_en;
      mem_src_rd <= i_EX_src_rd;
      wb_rd      <= mem_rd;
      wb_wr_en   <= mem_wr_en;
    end
  end

  // Only ALU results exist at MEM; loads and other late sources come from WB.
  logic mem_fwd_ok;
  logic wb_fwd_ok;
  assign mem_fwd_ok = mem_wr_en && (mem_rd != 5'd0) && (mem_src_rd == SRC_ALU);
  assign wb_fwd_ok  = wb_wr_en && (wb_rd != 5'd0);

  always_comb begin
    o_EX_fwd_sel_a = SEL_RF;
    if (mem_fwd_ok && (mem_rd == i_EX_rs1))     o_EX_fwd_sel_a = SEL_MEM;
    else if (wb_fwd_ok && (wb_rd == i_EX_rs1))  o_EX_fwd_sel_a = SEL_WB;
  end

  always_comb begin
    o_EX_fwd_sel_b = SEL_RF;
    if (mem_fwd_ok && (mem_rd == i_EX_rs2))     o_EX_fwd_sel_b = SEL_MEM;
    else if (wb_fwd_ok && (wb_rd == i_EX_rs2))  o_EX_fwd_sel_b = SEL_WB;
  end

  logic late_hazard;
  logic redirect;
  assign late_hazard = i_EX_reg_wr_en && (i_EX_src_rd != SRC_ALU) && (i_EX_rd != 5'd0) &&
                       ((i_EX_rd == i_ID_rs1) || (i_EX_rd == i_ID_rs2));
  assign redirect    = (i_EX_src_pc != 2'd0);

  // A redirect squashes the ID consumer, so it cancels the stall.
  assign o_stall    = late_hazard && !redirect;
  assign o_flush_id = redirect;
  assign o_flush_ex = late_hazard || redirect;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (redirect) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_hazard.sv
// Self-checking bench for riscv_hazard: directed pipeline scenarios plus a
// randomized run against an instruction-history reference model.
module tb_riscv_hazard;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
  logic             ex_wr;
  logic [1:0]       ex_src_rd, ex_src_pc;
  logic [1:0]       sel_a, sel_b;
  logic             stall, flush_id, flush_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  riscv_hazard #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_EX_rs1(ex_rs1), .i_EX_rs2(ex_rs2), .i_EX_rd(ex_rd),
    .i_EX_reg_wr_en(ex_wr), .i_EX_src_rd(ex_src_rd), .i_EX_src_pc(ex_src_pc),
    .o_EX_fwd_sel_a(sel_a), .o_EX_fwd_sel_b(sel_b),
    .o_stall(stall), .o_flush_id(flush_id), .o_flush_ex(flush_ex),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the last two issued instructions (index 0 = one cycle ago).
  logic [4:0] h_rd[2];
  logic       h_wr[2];
  logic [1:0] h_src[2];
  int         stall_total, flush_total;

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      h_rd[i] = 5'd0; h_wr[i] = 1'b0; h_src[i] = 2'd0;
    end
    stall_total = 0;
    flush_total = 0;
  endtask

  // Youngest older instruction producing rs wins; loads are only visible two back.
  function automatic logic [1:0] model_sel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (h_wr[0] && h_rd[0] == rs) return (h_src[0] == 2'd0) ? 2'd1 : (h_wr[1] && h_rd[1] == rs ? 2'd2 : 2'd0);
    if (h_wr[1] && h_rd[1] == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_late();
    return ex_wr && ex_src_rd != 2'd0 && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  task automatic drive(input logic [4:0] a_rs1, a_rs2, a_rd, input logic a_wr,
                       input logic [1:0] a_src, a_pc, input logic [4:0] a_id1, a_id2);
    ex_rs1 = a_rs1; ex_rs2 = a_rs2; ex_rd = a_rd; ex_wr = a_wr;
    ex_src_rd = a_src; ex_src_pc = a_pc; id_rs1 = a_id1; id_rs2 = a_id2;
  endtask

  task automatic nop();
    drive(0, 0, 0, 1'b0, 2'd0, 2'd0, 0, 0);
  endtask

  task automatic tick();
    if (!rstn) model_clear();
    else begin
      if (model_late() && ex_src_pc == 2'd0) stall_total++;
      if (ex_src_pc != 2'd0) flush_total++;
      h_rd[1] = h_rd[0]; h_wr[1] = h_wr[0]; h_src[1] = h_src[0];
      h_rd[0] = ex_rd;   h_wr[0] = ex_wr;   h_src[0] = ex_src_rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle_nops();
    nop(); tick(); nop(); tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(5, 6, 0, 1'b0, 2'd0, 2'd0, 0, 0);
    model_clear();
    #12;
    n_cmp++; if (sel_a !== 2'd0 || sel_b !== 2'd0) begin n_err++; $display("FAIL reset_sel: got a=%0d b=%0d want 0 0", sel_a, sel_b); end
    n_cmp++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_err++; $display("FAIL reset_cnt: got s=%0d f=%0d want 0 0", stall_cnt, flush_cnt); end
    n_cmp++; if (stall !== 1'b0 || flush_id !== 1'b0 || flush_ex !== 1'b0) begin n_err++; $display("FAIL reset_ctl: got %b%b%b want 000", stall, flush_id, flush_ex); end
    @(posedge clk); #1;
    rstn = 1'b1;
    settle_nops();
  endtask

  task automatic test_alu_b2b();
    drive(1, 2, 5, 1'b1, 2'd0, 2'd0, 5, 1);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_no_stall: got %b want 0", stall); end
    tick();
    drive(5, 1, 6, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd1 || sel_b !== 2'd0) begin n_err++; $display("FAIL b2b_sel: got a=%0d b=%0d want 1 0", sel_a, sel_b); end
    tick();
    settle_nops();
  endtask

  task automatic test_distance2_double();
    drive(1, 2, 5, 1'b1, 2'd0, 2'd0, 0, 0); tick();
    nop(); tick();
    drive(1, 5, 7, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd0 || sel_b !== 2'd2) begin n_err++; $display("FAIL dist2_sel: got a=%0d b=%0d want 0 2", sel_a, sel_b); end
    tick();
    settle_nops();
    drive(1, 0, 5, 1'b1, 2'd0, 2'd0, 0, 0); tick();
    drive(5, 0, 5, 1'b1, 2'd0, 2'd0, 0, 0); tick();
    drive(5, 5, 8, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd1 || sel_b !== 2'd1) begin n_err++; $display("FAIL double_hit_sel: got a=%0d b=%0d want 1 1", sel_a, sel_b); end
    tick();
    settle_nops();
  endtask

  task automatic test_load_use();
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL lu_cnt_before: got %0d want 0", stall_cnt); end
    drive(1, 0, 5, 1'b1, 2'd1, 2'd0, 5, 0);
    #1;
    n_cmp++; if (stall !== 1'b1 || flush_ex !== 1'b1 || flush_id !== 1'b0) begin n_err++; $display("FAIL lu_stall: got s=%b fe=%b fi=%b want 1 1 0", stall, flush_ex, flush_id); end
    tick();
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); end
    drive(0, 0, 0, 1'b0, 2'd0, 2'd0, 5, 0);
    #1;
    n_cmp++; if (stall !== 1'b0 || flush_ex !== 1'b0) begin n_err++; $display("FAIL lu_one_cycle: got s=%b fe=%b want 0 0", stall, flush_ex); end
    tick();
    drive(5, 0, 6, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd2) begin n_err++; $display("FAIL lu_sel_a: got %0d want 2", sel_a); end
    tick();
    settle_nops();
  endtask

  task automatic test_branch_hazard();
    logic [CNT_W-1:0] f0, s0;
    f0 = flush_cnt; s0 = stall_cnt;
    drive(1, 0, 5, 1'b1, 2'd1, 2'd1, 5, 0);
    #1;
    n_cmp++; if (flush_id !== 1'b1 || flush_ex !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL br_ctl: got fi=%b fe=%b s=%b want 1 1 0", flush_id, flush_ex, stall); end
    tick();
    n_cmp++; if (flush_cnt !== f0 + 4'd1 || stall_cnt !== s0) begin n_err++; $display("FAIL br_cnt: got f=%0d s=%0d want %0d %0d", flush_cnt, stall_cnt, f0 + 4'd1, s0); end
    settle_nops();
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 1'b1, 2'd1, 2'd0, 0, 0);
    #1;
    n_cmp++; if (stall !== 1'b0 || flush_ex !== 1'b0) begin n_err++; $display("FAIL x0_stall: got s=%b fe=%b want 0 0", stall, flush_ex); end
    tick();
    drive(1, 2, 0, 1'b1, 2'd0, 2'd0, 0, 0); tick();
    drive(0, 0, 9, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd0 || sel_b !== 2'd0) begin n_err++; $display("FAIL x0_sel: got a=%0d b=%0d want 0 0", sel_a, sel_b); end
    tick();
    settle_nops();
  endtask

  task automatic test_reset_midstream();
    drive(1, 2, 5, 1'b1, 2'd0, 2'd0, 0, 0); tick();
    drive(5, 5, 6, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd1) begin n_err++; $display("FAIL mid_pre_sel: got %0d want 1", sel_a); end
    rstn = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (sel_a !== 2'd0 || sel_b !== 2'd0) begin n_err++; $display("FAIL mid_rst_sel: got a=%0d b=%0d want 0 0", sel_a, sel_b); end
    n_cmp++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_err++; $display("FAIL mid_rst_cnt: got s=%0d f=%0d want 0 0", stall_cnt, flush_cnt); end
    nop(); tick();
    rstn = 1'b1;
    drive(5, 5, 6, 1'b1, 2'd0, 2'd0, 0, 0);
    #1;
    n_cmp++; if (sel_a !== 2'd0 || sel_b !== 2'd0) begin n_err++; $display("FAIL mid_post_sel: got a=%0d b=%0d want 0 0", sel_a, sel_b); end
    tick();
    settle_nops();
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    logic       el, es, efi, efe;
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0) begin
        rstn = 1'b0;
        model_clear();
      end
      #1;
      ea = model_sel(ex_rs1); eb = model_sel(ex_rs2);
      el = model_late();
      efi = (ex_src_pc != 2'd0);
      es = el && !efi;
      efe = el || efi;
      n_cmp++; if (sel_a !== ea || sel_b !== eb) begin n_err++; $display("FAIL rnd_sel[%0d]: got a=%0d b=%0d want %0d %0d", i, sel_a, sel_b, ea, eb); end
      n_cmp++; if (stall !== es || flush_id !== efi || flush_ex !== efe) begin n_err++; $display("FAIL rnd_ctl[%0d]: got s=%b fi=%b fe=%b want %b %b %b", i, stall, flush_id, flush_ex, es, efi, efe); end
      tick();
      rstn = 1'b1;
      n_cmp++; if (stall_cnt !== CNT_W'(stall_total) || flush_cnt !== CNT_W'(flush_total)) begin n_err++; $display("FAIL rnd_cnt[%0d]: got s=%0d f=%0d want %0d %0d", i, stall_cnt, flush_cnt, CNT_W'(stall_total), CNT_W'(flush_total)); end
    end
    settle_nops();
  endtask

  task automatic test_counter_wrap();
    rstn = 1'b0;
    model_clear();
    nop(); tick();
    rstn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 0, 1'b0, 2'd0, 2'(1 + (i % 2)), 0, 0);
      tick();
    end
    n_cmp++; if (flush_cnt !== 4'd1) begin n_err++; $display("FAIL cnt_wrap: got %0d want 1", flush_cnt); end
    nop(); tick();
  endtask

  initial begin
    test_reset();
    test_alu_b2b();
    test_distance2_double();
    test_load_use();
    test_branch_hazard();
    test_x0();
    test_reset_midstream();
    test_random();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_hazard.md
# riscv_hazard

Hazard and forwarding controller for the 5-stage RISC-V pipeline, sitting opposite the EX stage. It tracks destination registers of instructions already past EX, drives the EX operand-forwarding selects, and detects load-use and late-result hazards. On a hazard it stalls IF/ID and issues bubbles, and on redirected control flow it flushes wrong-path instructions. It also keeps stall and flush event counters for performance debug.

## Interface
- XLEN, 32: datapath width; only sets the width of the `i_EX_*` data fields that are not used here.
- CNT_W, 16: width of the stall and flush counters.

- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rstn  input  1  asynchronous, active-low reset.
- i_ID_rs1  input  5  rs1 of the instruction in ID.
- i_ID_rs2  input  5  rs2 of the instruction in ID.
- i_EX_rs1  input  5  rs1 of the instruction in EX.
- i_EX_rs2  input  5  rs2 of the instruction in EX.
- i_EX_rd  input  5  rd of the instruction in EX.
- i_EX_reg_wr_en  input  1  the EX instruction writes rd.
- i_EX_src_rd  input  2  writeback source of the EX instruction: 0 = ALU, 1 = load data, 2 = pc+4, 3 = imm.
- i_EX_src_pc  input  2  next-PC select from the ALU: 0 = pc+4, 1 = pc+imm, 2 = ALU (jalr). Nonzero means taken.
- o_EX_fwd_sel_a  output  2  rs1 operand select: 0 = register file, 1 = MEM alu_out, 2 = WB rd_data.
- o_EX_fwd_sel_b  output  2  rs2 operand select, same encoding as o_EX_fwd_sel_a.
- o_stall  output  1  hold PC and the IF/ID register.
- o_flush_id  output  1  turn IF/ID into a NOP.
- o_flush_ex  output  1  turn ID/EX into a bubble (all write enables 0).
- o_stall_cnt  output  CNT_W  number of cycles with o_stall high.
- o_flush_cnt  output  CNT_W  number of taken redirects.

## Operation
- Shadow pipeline registers:
  - mem_rd, mem_wr_en, mem_src_rd are loaded from the i_EX_* fields every cycle.
  - wb_rd, wb_wr_en are loaded from the mem_* registers every cycle.
  - They are never gated by stall. A bubble arrives as i_EX_reg_wr_en = 0 the following cycle.
- Forwarding for operand A (operand B is identical, using i_EX_rs2):
  - sel = 1 if mem_wr_en && mem_rd != 0 && mem_rd == i_EX_rs1 && mem_src_rd == 0.
  - Otherwise sel = 2 if wb_wr_en && wb_rd != 0 && wb_rd == i_EX_rs1.
  - Otherwise sel = 0.
  - When both MEM and WB match, MEM wins (youngest producer).
- Late-result hazard (stall):
  - Condition: i_EX_reg_wr_en, i_EX_src_rd != 0, i_EX_rd != 0, and i_EX_rd equals i_ID_rs1 or i_ID_rs2.
  - Response: o_stall = 1 and o_flush_ex = 1 for exactly one cycle.
  - On the next cycle the producer is in MEM with src_rd != 0. The consumer then reaches EX one cycle later, when the producer is in WB, and gets sel = 2.
- Control hazard:
  - Condition: i_EX_src_pc != 0.
  - Response: o_flush_id = 1 and o_flush_ex = 1 in the same cycle.
- Priority: a flush overrides a stall. If both conditions hold, o_stall = 0 because the ID instruction is squashed.
- Counters:
  - o_stall_cnt increments on every cycle with o_stall high.
  - o_flush_cnt increments on every cycle with i_EX_src_pc != 0.
  - Both wrap modulo 2^CNT_W.
- x0: rd = 0 never causes forwarding or a stall.

## Timing
- All outputs except the counters are combinational from the current inputs and the shadow registers, in the same cycle. There is no added latency.
- Counters and shadow registers update on the rising edge of i_clk.
- Reset (i_rstn low, asynchronous):
  - mem_wr_en = wb_wr_en = 0; mem_rd = wb_rd = 0; mem_src_rd = 0.
  - Counters = 0.
  - Consequently o_EX_fwd_sel_a/b = 0 during and right after reset. o_stall and o_flush_* follow the inputs, which are driven as bubbles in reset.
- Reset deassertion mid-operation: the first edge after release loads the shadow registers from EX. No forwarding happens from pre-reset instructions.
- A stall never lasts more than one consecutive cycle for the same producer/consumer pair.

## Test plan
- ALU back-to-back: `add x5` then `sub x6,x5,x1` → in the sub's EX cycle o_EX_fwd_sel_a = 1; o_stall stays 0.
- Distance 2 and double hit:
  - `add x5`, nop, `or x7,x1,x5` → o_EX_fwd_sel_b = 2.
  - `addi x5`, `addi x5`, `add x8,x5,x5` → both selects = 1.
- Load-use: `lw x5` then `add x6,x5,x0` → o_stall = 1 and o_flush_ex = 1 for one cycle. The add reaches EX two cycles after the lw with sel_a = 2. o_stall_cnt goes 0 → 1.
- Taken branch plus simultaneous hazard:
  - Stimulus: i_EX_src_pc = 1 in the same cycle as the load-use condition.
  - Response: o_flush_id = o_flush_ex = 1, o_stall = 0, o_flush_cnt += 1.
- x0 and reset:
  - Writes to x0 produce sel = 0 and no stall.
  - Pulse i_rstn low mid-stream: all selects = 0 and both counters = 0 immediately, without waiting for a clock edge.
- Counter wrap: with CNT_W = 4, apply 17 taken redirects → o_flush_cnt = 1.
